// File: rtl/de0_lt24_sopc_pio_pkg.sv
// Shared definitions for the SOPC parallel I/O blocks.
// Register word addresses and edge-capture mode encodings.
package de0_lt24_sopc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_e;

  function automatic logic edge_event(
    input int   mode,
    input logic cur,
    input logic prv
  );
    if (mode == int'(EDGE_FALL)) return ~cur & prv;
    if (mode == int'(EDGE_ANY))  return cur ^ prv;
    return cur & ~prv;
  endfunction

endpackage

// File: rtl/de0_lt24_sopc_signal_in_filter.sv
// Per-bit input conditioning: synchroniser, optional debounce,
// and edge detection against the previous filtered level.
module pio_in_bit_filter
  import de0_lt24_sopc_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic primed,
  output logic filt,
  output logic ev
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign s = sync[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign filt = s;
  end else begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          f;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt <= '0;
        f   <= 1'b0;
      end else if (s == f) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        f   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign filt = f;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= filt;
  end

  assign ev = primed & edge_event(EDGE_TYPE, filt, prev);

endmodule

// File: rtl/de0_lt24_sopc_signal_in.sv
// Avalon-MM input PIO: filtered input data, edge capture
// with write-one-to-clear, and a maskable level interrupt.
module de0_lt24_sopc_signal_in
  import de0_lt24_sopc_pio_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Hold off edges until a level present at reset has fully
  // propagated through the chain and any debounce window.
  localparam int PRIME = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
  localparam int PW    = $clog2(PRIME + 1);

  logic [PW-1:0]    pcnt;
  logic             primed;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] cap_next;
  logic             wr;
  logic             unused_ok;

  assign primed = (pcnt == PW'(PRIME));

  always_ff @(posedge clk) begin
    if (!reset_n)     pcnt <= '0;
    else if (!primed) pcnt <= pcnt + PW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_in_bit_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_TYPE       (EDGE_TYPE)
    ) u_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .primed  (primed),
      .filt    (filt[i]),
      .ev      (ev[i])
    );
  end

  assign wr = chipselect & ~write_n;

  always_comb begin
    clr       = '0;
    mask_next = irq_mask;
    if (wr && address == ADDR_EDGECAP) clr       = writedata[WIDTH-1:0];
    if (wr && address == ADDR_IRQMASK) mask_next = writedata[WIDTH-1:0];
    cap_next = (edge_cap & ~clr) | ev;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      irq_mask <= mask_next;
      edge_cap <= cap_next;
      irq      <= |(cap_next & mask_next);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = filt;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
      default:      readdata = '0;
    endcase
  end

  assign unused_ok = &{1'b0, writedata};

endmodule

// File: tb/tb_de0_lt24_sopc_signal_in.sv
// Scoreboard bench: rising-edge PIO against a delayed-history model,
// plus a debounced any-edge instance with hand-derived expectations.
module tb_de0_lt24_sopc_signal_in;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs0 = 1'b0;
  logic        cs1 = 1'b0;
  logic        write_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = '0;
  logic [15:0] in0 = 16'hFFFF;
  logic [15:0] in1 = 16'h0080;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  always #5 clk = ~clk;

  de0_lt24_sopc_signal_in #(
    .WIDTH(16), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs0), .write_n(write_n), .writedata(writedata),
    .in_port(in0), .readdata(rd0), .irq(irq0)
  );

  de0_lt24_sopc_signal_in #(
    .WIDTH(16), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs1), .write_n(write_n), .writedata(writedata),
    .in_port(in1), .readdata(rd1), .irq(irq1)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  string       t0[$];
  string       t1[$];
  string       cur_tag = "";

  // Model of u0: filtered value is the input from SYNC cycles ago.
  bit          mvalid = 0;
  int          since = 0;
  logic [15:0] m_ec = '0;
  logic [15:0] m_mask = '0;
  logic        m_irq = 1'b0;
  logic [15:0] hist[$];

  function automatic logic [15:0] m_filt(int n);
    if (since >= SYNC) return hist[n-SYNC];
    return 16'h0;
  endfunction

  function automatic logic [15:0] m_ev(int n);
    logic [15:0] cur, prv;
    if (since < SYNC + 1) return 16'h0;
    cur = hist[n-SYNC];
    prv = hist[n-SYNC-1];
    return cur & ~prv;
  endfunction

  task automatic tick();
    int          n;
    logic [15:0] ev, clr, rdv;
    n = hist.size();
    hist.push_back(in0);
    if (mvalid && cs0 && write_n) begin
      case (address)
        2'd0:    rdv = m_filt(n);
        2'd2:    rdv = m_mask;
        2'd3:    rdv = m_ec;
        default: rdv = 16'h0;
      endcase
      q0.push_back({m_irq, 16'h0, rdv});
      t0.push_back(cur_tag);
    end
    ev = mvalid ? m_ev(n) : 16'h0;
    @(posedge clk);
    if (!reset_n) begin
      mvalid = 1;
      since  = 0;
      m_ec   = '0;
      m_mask = '0;
      m_irq  = 1'b0;
    end else if (mvalid) begin
      since++;
      clr = '0;
      if (cs0 && !write_n && address == 2'd2) m_mask = writedata[15:0];
      if (cs0 && !write_n && address == 2'd3) clr = writedata[15:0];
      m_ec  = (m_ec & ~clr) | ev;
      m_irq = |(m_ec & m_mask);
    end
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic rd0_t(logic [1:0] a, string tag);
    cs0 = 1'b1; write_n = 1'b1; address = a; cur_tag = tag;
    tick();
    cs0 = 1'b0;
  endtask

  task automatic wr0_t(logic [1:0] a, logic [31:0] d);
    cs0 = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    cs0 = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd1_t(logic [1:0] a, logic [31:0] d, logic i, string tag);
    cs1 = 1'b1; write_n = 1'b1; address = a;
    q1.push_back({i, d});
    t1.push_back(tag);
    tick();
    cs1 = 1'b0;
  endtask

  task automatic wr1_t(logic [1:0] a, logic [31:0] d);
    cs1 = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    cs1 = 1'b0; write_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    string       tg;
    if (cs0 && write_n) begin
      n_chk++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL u0_unexpected_read: got irq=%0b data=%h, no entry required",
                 irq0, rd0);
      end else begin
        e  = q0.pop_front();
        tg = t0.pop_front();
        if ({irq0, rd0} !== e) begin
          n_fail++;
          $display("FAIL %s: got irq=%0b data=%h, expected irq=%0b data=%h",
                   tg, irq0, rd0, e[32], e[31:0]);
        end
      end
    end
    if (cs1 && write_n) begin
      n_chk++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL u1_unexpected_read: got irq=%0b data=%h, no entry required",
                 irq1, rd1);
      end else begin
        e  = q1.pop_front();
        tg = t1.pop_front();
        if ({irq1, rd1} !== e) begin
          n_fail++;
          $display("FAIL %s: got irq=%0b data=%h, expected irq=%0b data=%h",
                   tg, irq1, rd1, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(10);

    rd0_t(2'd0, "t1_data");
    rd0_t(2'd3, "t1_ecap");
    rd0_t(2'd1, "t1_rsvd");
    rd0_t(2'd2, "t1_mask");
    rd1_t(2'd0, 32'h0080, 1'b0, "u1_reset_data");
    rd1_t(2'd3, 32'h0000, 1'b0, "u1_reset_ecap");

    in1 = 16'h0088;
    idle(3);
    in1 = 16'h0080;
    idle(10);
    rd1_t(2'd0, 32'h0080, 1'b0, "glitch_data");
    rd1_t(2'd3, 32'h0000, 1'b0, "glitch_ecap");

    in1 = 16'h0088;
    idle(5);
    rd1_t(2'd0, 32'h0080, 1'b0, "hold_data_pre");
    rd1_t(2'd0, 32'h0088, 1'b0, "hold_data");
    rd1_t(2'd3, 32'h0008, 1'b0, "hold_ecap");
    idle(5);
    rd1_t(2'd3, 32'h0008, 1'b0, "hold_one_capture");
    wr1_t(2'd3, 32'h0000_0008);
    rd1_t(2'd3, 32'h0000, 1'b0, "hold_cleared");

    in1 = 16'h0008;
    idle(8);
    in1 = 16'h0088;
    idle(10);
    rd1_t(2'd3, 32'h0080, 1'b0, "any_ecap");
    wr1_t(2'd2, 32'h0000_0080);
    rd1_t(2'd2, 32'h0080, 1'b1, "any_irq");
    wr1_t(2'd2, 32'h0000_0000);
    rd1_t(2'd3, 32'h0080, 1'b0, "any_unmask");

    wr0_t(2'd2, 32'h0000_0005);
    in0 = 16'hFFFE;
    idle(6);
    in0 = 16'hFFFF;
    repeat (6) rd0_t(2'd3, "t2_ecap");
    wr0_t(2'd3, 32'h0000_0001);
    repeat (3) rd0_t(2'd2, "t2_after_clr");

    in0 = 16'hFFFB;
    idle(6);
    in0 = 16'hFFFF;
    idle(2);
    wr0_t(2'd3, 32'h0000_0004);
    repeat (3) rd0_t(2'd3, "t3_set_wins");

    wr0_t(2'd3, 32'h0000_FFFF);
    in0 = 16'hFF00;
    idle(6);
    in0 = 16'hFFFF;
    idle(6);
    rd0_t(2'd3, "t6_pre_reset");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rd0_t(2'(i % 4), "t6_after_reset");
    end

    repeat (600) begin
      if ($urandom_range(0, 2) == 0)
        in0 = in0 ^ (16'h1 << $urandom_range(0, 15));
      else if ($urandom_range(0, 19) == 0)
        in0 = 16'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 55) begin
        rd0_t(2'($urandom_range(0, 3)), "rand_read");
      end else if (r < 65) begin
        wr0_t(2'd2, $urandom);
      end else if (r < 77) begin
        wr0_t(2'd3, $urandom);
      end else if (r < 82) begin
        wr0_t(2'($urandom_range(0, 1)), $urandom);
      end else if (r < 84) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end

    idle(2);
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0",
               q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
